scene_renderer: RTL
===================

Name: scene_renderer

Overview:
- Display-side counterpart of the game controller.
- Consumes paddle, ball and block state and generates 640x480 VGA timing and pixel colour.
- Emits the one-cycle FRAME_RENDERED strobe that starts each physics update.
- Snapshots game state at frame start, so a frame never tears while physics updates in the background.

Parameters:
- PADDLE_WIDTH, 64, paddle width in pixels.
- PADDLE_Y, 448, paddle top row; paddle is 8 rows tall.
- BALL_SIZE, 8, ball edge length in pixels (square, top-left anchored).
- COLOR_BG, 8'h00, background colour (RGB332).
- COLOR_BORDER, 8'h92, playfield border colour.
- COLOR_BLOCK, 8'hE0, block colour.
- COLOR_PADDLE, 8'h1F, paddle colour.
- COLOR_BALL, 8'hFF, ball colour.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-low.
- PIX_EN  in  1  pixel-rate enable (one CLK every 4 at 100 MHz); all timing state advances only when high.
- PADDLE_X_PIXEL  in  10  paddle left edge.
- BALL_X_PIXEL  in  10  ball left edge.
- BALL_Y_PIXEL  in  10  ball top edge.
- BLOCK_STATE  in  72  block alive bits; index = row*12 + col.
- FRAME_RENDERED  out  1  one-CLK pulse after the last visible pixel of each frame.
- HSYNC  out  1  horizontal sync, active-low.
- VSYNC  out  1  vertical sync, active-low.
- RGB  out  8  pixel colour RGB332; 0 outside the visible area.

Behaviour:
- Timing counters:
  - hcnt counts 0..799 and vcnt counts 0..524; both advance on PIX_EN only.
  - hcnt wraps to 0 and increments vcnt; vcnt wraps 524->0.
  - Visible area: h 0..639, v 0..479.
  - HSYNC low for h 656..751; VSYNC low for v 490..491.
- Snapshot:
  - On PIX_EN with hcnt=799 and vcnt=524 (the tick before pixel 0,0), register PADDLE_X, BALL_X, BALL_Y and BLOCK_STATE into shadow registers.
  - All drawing uses the shadows only.
  - Input changes at any other time have no effect until the next snapshot.
- Block grid:
  - 12 columns x 6 rows; blocks are 48x16 px.
  - Field spans x 32..607, y 48..143.
  - Column and row are tracked by sub-counters, not division:
    - col_px 0..47 and col 0..11 reset at h=32 and advance per pixel.
    - row_px 0..15 and row 0..5 reset at v=48 and advance per line.
  - The 1-px gap at col_px=47 or row_px=15 is not drawn as block.
- Border: 8-px frame at x 0..7, x 632..639 and y 0..7, visible area only; no bottom border.
- Hit tests:
  - Ball: h-bx in [0,BALL_SIZE) and v-by in [0,BALL_SIZE), unsigned 11-bit compare.
  - Paddle: h-px in [0,PADDLE_WIDTH) and v-PADDLE_Y in [0,8).
  - Ball or paddle partially off-screen clips naturally; no wrap-around drawing.
- Priority: ball > paddle > alive block > border > background.
- Pipeline: 2 PIX_EN stages.
  - Stage 1 registers hit flags.
  - Stage 2 registers RGB.
  - HSYNC and VSYNC are delayed 2 stages to stay aligned with RGB.
- FRAME_RENDERED:
  - Single-CLK pulse (not PIX_EN-wide) in the CLK cycle after the PIX_EN tick where stage 2 outputs pixel (639,479).
  - Exactly one pulse per frame.
- Reset values, forced asynchronously when RESET low:
  - hcnt=vcnt=0; pipeline and shadows cleared.
  - RGB=0, HSYNC=1, VSYNC=1, FRAME_RENDERED=0.
- After reset release, the first frame draws with cleared shadows: no blocks; ball and paddle at 0,0.
- Real state appears from the second frame.
- Reset mid-frame aborts the frame with no FRAME_RENDERED pulse.
- PIX_EN low holds all state, including pipeline stages; FRAME_RENDERED is never repeated during a stall.

Test Plan:
- Reset, then run 2 frames -> HSYNC period 800 ticks, low ticks 656..751 (+2 latency); VSYNC low for lines 490..491; RGB=0 in blanking.
- Count FRAME_RENDERED over 3 frames -> exactly 3 one-CLK pulses, each 1 CLK after the PIX_EN that outputs pixel (639,479).
- BLOCK_STATE bit 0 = 1, others 0 -> pixels (32..78, 48..62) = 8'hE0; pixel (79,48) = border/bg; bit 0 = 0 next frame -> 8'h00.
- Ball at (100,448), paddle at 96 -> pixels (100..107,448..455) = 8'hFF; (96..99,448) = 8'h1F.
- Change BALL_X from 100 to 300 at v=200 -> ball still drawn at x=100 rows 200+; x=300 appears only from the next frame.
- Assert RESET at v=240 -> outputs take reset values immediately, no FRAME_RENDERED that frame; timing restarts at 0,0 on release.

Source files
------------

// File: rtl/scene_renderer_if.sv
// Game-state inputs and VGA outputs of the scene renderer.
interface scene_renderer_if;
    // There is no valid/ready pair. pix_en qualifies each pixel tick. Game state is sampled only at the
    // frame-start snapshot. rgb/hsync/vsync change on pix_en ticks, and frame_rendered is a one-clk strobe.
    logic        pix_en;
    logic [9:0]  paddle_x_pixel;
    logic [9:0]  ball_x_pixel;
    logic [9:0]  ball_y_pixel;
    logic [71:0] block_state;
    logic        frame_rendered;
    logic        hsync;
    logic        vsync;
    logic [7:0]  rgb;

    modport master (
        output pix_en, paddle_x_pixel, ball_x_pixel, ball_y_pixel, block_state,
        input  frame_rendered, hsync, vsync, rgb
    );

    modport slave (
        input  pix_en, paddle_x_pixel, ball_x_pixel, ball_y_pixel, block_state,
        output frame_rendered, hsync, vsync, rgb
    );
endinterface

// File: rtl/scene_renderer.sv
// VGA timing plus playfield drawing from a per-frame snapshot of game state,
// with a two-stage pixel pipeline and an end-of-frame strobe.
module scene_renderer #(
    parameter int         PADDLE_WIDTH = 64,
    parameter int         PADDLE_Y     = 448,
    parameter int         BALL_SIZE    = 8,
    parameter logic [7:0] COLOR_BG     = 8'h00,
    parameter logic [7:0] COLOR_BORDER = 8'h92,
    parameter logic [7:0] COLOR_BLOCK  = 8'hE0,
    parameter logic [7:0] COLOR_PADDLE = 8'h1F,
    parameter logic [7:0] COLOR_BALL   = 8'hFF,
    parameter int         H_VISIBLE    = 640,
    parameter int         H_SYNC_START = 656,
    parameter int         H_SYNC_END   = 752,
    parameter int         H_TOTAL      = 800,
    parameter int         V_VISIBLE    = 480,
    parameter int         V_SYNC_START = 490,
    parameter int         V_SYNC_END   = 492,
    parameter int         V_TOTAL      = 525
) (
    input logic             clk,
    input logic             rst_n,
    scene_renderer_if.slave bus
);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]  V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  H_SS       = 10'(H_SYNC_START);
    localparam logic [9:0]  H_SE       = 10'(H_SYNC_END);
    localparam logic [9:0]  V_SS       = 10'(V_SYNC_START);
    localparam logic [9:0]  V_SE       = 10'(V_SYNC_END);
    localparam logic [9:0]  FIELD_X0   = 10'd32;
    localparam logic [9:0]  FIELD_X1   = 10'd608;
    localparam logic [9:0]  FIELD_Y0   = 10'd48;
    localparam logic [9:0]  FIELD_Y1   = 10'd144;
    localparam logic [10:0] BALL_LIM   = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_W      = 11'(PADDLE_WIDTH);
    localparam logic [10:0] PAD_Y      = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_H      = 11'd8;

    logic [9:0]  hcnt, vcnt;
    logic        line_end, frame_end;
    logic [9:0]  paddle_x_s, ball_x_s, ball_y_s;
    logic [71:0] block_s;
    logic [5:0]  col_px;
    logic [3:0]  col;
    logic [3:0]  row_px;
    logic [2:0]  row;

    assign line_end  = bus.pix_en && (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (bus.pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Loaded on the tick just before pixel (0,0) so a whole frame draws from one consistent state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddle_x_s <= '0;
            ball_x_s   <= '0;
            ball_y_s   <= '0;
            block_s    <= '0;
        end else if (frame_end) begin
            paddle_x_s <= bus.paddle_x_pixel;
            ball_x_s   <= bus.ball_x_pixel;
            ball_y_s   <= bus.ball_y_pixel;
            block_s    <= bus.block_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_px <= '0;
            col    <= '0;
        end else if (bus.pix_en) begin
            if (hcnt == FIELD_X0 - 10'd1) begin
                col_px <= '0;
                col    <= '0;
            end else if (col_px == 6'd47) begin
                col_px <= '0;
                if (col != 4'd11) col <= col + 4'd1;
            end else begin
                col_px <= col_px + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_px <= '0;
            row    <= '0;
        end else if (line_end) begin
            if (vcnt == FIELD_Y0 - 10'd1) begin
                row_px <= '0;
                row    <= '0;
            end else if (row_px == 4'd15) begin
                row_px <= '0;
                if (row != 3'd5) row <= row + 3'd1;
            end else begin
                row_px <= row_px + 4'd1;
            end
        end
    end

    // 11-bit differences: a pixel left of/above the object wraps to a large value and misses.
    logic [10:0] ball_dx, ball_dy, pad_dx, pad_dy;
    logic [6:0]  blk_idx;
    logic        visible, ball_hit, paddle_hit, in_field, block_hit, border_hit, hsync_n, vsync_n;

    assign ball_dx    = {1'b0, hcnt} - {1'b0, ball_x_s};
    assign ball_dy    = {1'b0, vcnt} - {1'b0, ball_y_s};
    assign pad_dx     = {1'b0, hcnt} - {1'b0, paddle_x_s};
    assign pad_dy     = {1'b0, vcnt} - PAD_Y;
    assign ball_hit   = (ball_dx < BALL_LIM) && (ball_dy < BALL_LIM);
    assign paddle_hit = (pad_dx < PAD_W) && (pad_dy < PAD_H);
    assign blk_idx    = 7'(row) * 7'd12 + 7'(col);
    assign in_field   = (hcnt >= FIELD_X0) && (hcnt < FIELD_X1) && (vcnt >= FIELD_Y0) && (vcnt < FIELD_Y1);
    assign block_hit  = in_field && (col_px != 6'd47) && (row_px != 4'd15) && block_s[blk_idx];
    assign visible    = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign border_hit = (hcnt < 10'd8) || (hcnt >= H_VIS - 10'd8) || (vcnt < 10'd8);
    assign hsync_n    = !((hcnt >= H_SS) && (hcnt < H_SE));
    assign vsync_n    = !((vcnt >= V_SS) && (vcnt < V_SE));

    logic s1_vis, s1_ball, s1_paddle, s1_block, s1_border, s1_hsync, s1_vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vis    <= 1'b0;
            s1_ball   <= 1'b0;
            s1_paddle <= 1'b0;
            s1_block  <= 1'b0;
            s1_border <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
        end else if (bus.pix_en) begin
            s1_vis    <= visible;
            s1_ball   <= ball_hit;
            s1_paddle <= paddle_hit;
            s1_block  <= block_hit;
            s1_border <= border_hit;
            s1_hsync  <= hsync_n;
            s1_vsync  <= vsync_n;
        end
    end

    logic [7:0] pix_color;

    always_comb begin
        pix_color = 8'h00;
        if (s1_vis) begin
            if (s1_ball)        pix_color = COLOR_BALL;
            else if (s1_paddle) pix_color = COLOR_PADDLE;
            else if (s1_block)  pix_color = COLOR_BLOCK;
            else if (s1_border) pix_color = COLOR_BORDER;
            else                pix_color = COLOR_BG;
        end
    end

    logic [7:0] rgb_q;
    logic       hsync_q, vsync_q, frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (bus.pix_en) begin
            rgb_q   <= pix_color;
            hsync_q <= s1_hsync;
            vsync_q <= s1_vsync;
        end
    end

    // Counters at (H_VIS, last visible line) mean stage 2 is taking the final visible pixel on this tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= 1'b0;
        else        frame_q <= bus.pix_en && (hcnt == H_VIS) && (vcnt == V_VIS_LAST);
    end

    assign bus.rgb            = rgb_q;
    assign bus.hsync          = hsync_q;
    assign bus.vsync          = vsync_q;
    assign bus.frame_rendered = frame_q;
endmodule
